handshake_fwd_pipe: RTL and testbench
=====================================

Name: handshake_fwd_pipe

Overview:
- Forward-registered valid/ready pipeline.
- Counterpart to the team's ready-cut bypass buffer. That buffer registers the backward (ready) path. This block registers the forward path: valid and data.
- Each of STAGES stages holds one beat. valid_post_o and data_o come straight from flops. Ready ripples combinationally upstream.
- Placed between producer and consumer to close timing on long forward valid/data routes, at full throughput.

Parameters:
- DATA_W, 8: payload width in bits.
- STAGES, 2: number of register stages, legal range 1..8. Values outside this range are an elaboration error.
- CNT_W, $clog2(STAGES+1): width of occupancy_o. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush; discards all held beats.
- valid_pre_i  in  1  upstream beat valid.
- ready_pre_o  out  1  block accepts the upstream beat this cycle.
- data_i  in  DATA_W  upstream payload.
- valid_post_o  out  1  downstream beat valid. Driven directly from a register.
- ready_post_i  in  1  downstream accepts the beat.
- data_o  out  DATA_W  downstream payload. Driven directly from a register.
- occupancy_o  out  CNT_W  number of valid stages, 0..STAGES.

Behaviour:
- Stage registers: v[k] and d[k], for k = 0..STAGES-1. Stage 0 faces upstream; stage STAGES-1 drives valid_post_o and data_o.
- Stage ready: r[k] = !v[k] | r[k+1], with r[STAGES] = ready_post_i.
- ready_pre_o = r[0] & !flush_i.
- Ready is combinational from ready_post_i through all stages. This is intentional and accepted.
- Transfers:
  - Upstream-to-stage-0 transfer: valid_pre_i & ready_pre_o.
  - Stage k to k+1 transfer: v[k] & r[k+1].
  - Output transfer: valid_post_o & ready_post_i.
- Stage update each cycle, when flush_i=0:
  - If stage k has r[k]=1, it loads v[k] and d[k] from its source. The source is stage k-1, or the upstream inputs for k=0.
  - Otherwise the stage holds.
  - d[k] is written only when its source is valid. A stage that empties keeps its stale data.
- Latency: a beat entering an empty pipe appears on valid_post_o exactly STAGES cycles after the transfer cycle.
- Throughput: one beat per cycle sustained while ready_post_i=1. No bubbles are inserted.
- Backpressure: while ready_post_i=0, the pipe fills bubbles first. ready_pre_o drops only when all stages are valid.
- Stability: while valid_post_o=1 and ready_post_i=0, valid_post_o and data_o stay unchanged in the next cycle. The only exceptions are flush and reset.
- Ordering: beats are delivered in acceptance order. No loss or duplication except on flush.
- Simultaneous accept and emit on a full pipe: every stage shifts in the same cycle. Occupancy is unchanged and ready_pre_o stays 1.
- flush_i=1:
  - ready_pre_o is 0 that cycle, so no upstream transfer occurs.
  - All v[k] clear at the next edge; d[k] holds.
  - A downstream transfer in the flush cycle is still valid and counts as delivered.
- Reset (reset_n=0, any time, including mid-transfer):
  - All v[k]=0 and all d[k]=0 immediately.
  - Resulting outputs: valid_post_o=0, data_o=0, occupancy_o=0.
  - ready_pre_o follows ready_pre_o = !flush_i, because an empty pipe is ready.
  - In-flight beats are lost.
- occupancy_o: popcount of v[]. Combinational from registers only; no path from the inputs.
- Upstream protocol (valid held until accepted, data stable) is the producer's duty. The block does not check it.

Decomposition:
- Package handshake_pkg:
  - HS_DATA_W_DEFAULT = 8.
  - HS_MAX_STAGES = 8.
  - Shared with the ready-cut buffer.
- Sub-module handshake_fwd_stage:
  - Contents: one v/d register pair. Inputs in_valid, in_data, flush, out_ready. Outputs out_valid, out_data, in_ready.
  - Instantiated STAGES times in a generate loop.
  - The top level contains only the chaining and the occupancy popcount.

Test Plan:
- Reset, then idle: valid_post_o=0, data_o=0, occupancy_o=0, ready_pre_o=1.
- STAGES=2, ready_post_i=1, send 0x11 at cycle t: valid_post_o=1 with data_o=0x11 at t+2, and is 0 at t+1.
- Stream 0x01..0x10 back-to-back with ready_post_i=1: 16 beats out on consecutive cycles, in order. ready_pre_o is 1 throughout.
- ready_post_i=0, push 0xA0, 0xA1, 0xA2:
  - First two beats accepted; ready_pre_o=0 at the third, occupancy_o=2.
  - data_o holds 0xA0 stable.
  - Raising ready_post_i drains 0xA0, 0xA1, then 0xA2.
- Full pipe with valid_pre_i=1 and ready_post_i=1 in the same cycle: occupancy_o stays 2, ready_pre_o=1, order is preserved.
- Flush and mid-stream reset:
  - Full pipe, assert flush_i one cycle: ready_pre_o=0 that cycle, then occupancy_o=0 and valid_post_o=0.
  - Assert reset_n=0 mid-stream: outputs clear asynchronously, with no edge needed.

Source files
------------

// File: rtl/handshake_pkg.sv
// handshake_pkg: constants shared by the forward-registered pipe and the ready-cut buffer
package handshake_pkg;
    localparam int HS_DATA_W_DEFAULT = 8;
    localparam int HS_MAX_STAGES     = 8;
endpackage

// File: rtl/handshake_fwd_stage.sv
// handshake_fwd_stage: one valid/data register pair with combinational pass-through ready
module handshake_fwd_stage
    import handshake_pkg::*;
#(
    parameter int DATA_W = HS_DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              in_ready
);
    assign in_ready = !out_valid | out_ready;
    // Data only loads on a valid source beat so an emptied stage keeps stale payload
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
        end
    end
endmodule

// File: rtl/handshake_fwd_pipe.sv
// handshake_fwd_pipe: chain of forward-registered stages; valid/data from flops, ready ripples upstream
module handshake_fwd_pipe
    import handshake_pkg::*;
#(
    parameter int DATA_W = HS_DATA_W_DEFAULT,
    parameter int STAGES = 2,
    parameter int CNT_W  = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush_i,
    input  logic              valid_pre_i,
    output logic              ready_pre_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_post_o,
    input  logic              ready_post_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  occupancy_o
);
    if (STAGES < 1 || STAGES > HS_MAX_STAGES) begin : g_bad_stages
        $error("handshake_fwd_pipe: STAGES must be 1..%0d", HS_MAX_STAGES);
    end
    logic [STAGES:0] vld;
    logic [STAGES:0] rdy;
    logic [DATA_W-1:0] dat [STAGES+1];
    assign vld[0]       = valid_pre_i;
    assign dat[0]       = data_i;
    assign rdy[STAGES]  = ready_post_i;
    assign ready_pre_o  = rdy[0] & !flush_i;
    assign valid_post_o = vld[STAGES];
    assign data_o       = dat[STAGES];
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        handshake_fwd_stage #(.DATA_W(DATA_W)) u_stage (
            .clk       (clk),
            .reset_n   (reset_n),
            .flush     (flush_i),
            .in_valid  (vld[k]),
            .in_data   (dat[k]),
            .out_ready (rdy[k+1]),
            .out_valid (vld[k+1]),
            .out_data  (dat[k+1]),
            .in_ready  (rdy[k])
        );
    end
    always_comb begin
        occupancy_o = '0;
        for (int k = 1; k <= STAGES; k++) occupancy_o = occupancy_o + CNT_W'(vld[k]);
    end
endmodule

// File: tb/tb_handshake_fwd_pipe.sv
// tb_handshake_fwd_pipe: directed scenario tasks for the two-stage forward-registered pipe
module tb_handshake_fwd_pipe;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       flush_i = 1'b0;
    logic       valid_pre_i = 1'b0;
    logic       ready_pre_o;
    logic [7:0] data_i = '0;
    logic       valid_post_o;
    logic       ready_post_i = 1'b0;
    logic [7:0] data_o;
    logic [1:0] occupancy_o;
    int pass_cnt = 0;
    int total_cnt = 0;

    handshake_fwd_pipe #(.DATA_W(8), .STAGES(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush_i      (flush_i),
        .valid_pre_i  (valid_pre_i),
        .ready_pre_o  (ready_pre_o),
        .data_i       (data_i),
        .valid_post_o (valid_post_o),
        .ready_post_i (ready_post_i),
        .data_o       (data_o),
        .occupancy_o  (occupancy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        total_cnt++; if (valid_post_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_post_o); else pass_cnt++;
        total_cnt++; if (data_o !== 8'h00) $display("FAIL reset_data got=%h exp=00", data_o); else pass_cnt++;
        total_cnt++; if (occupancy_o !== 2'd0) $display("FAIL reset_occ got=%0d exp=0", occupancy_o); else pass_cnt++;
        total_cnt++; if (ready_pre_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready_pre_o); else pass_cnt++;
        tick();
    endtask

    task automatic test_latency();
        ready_post_i = 1'b1;
        valid_pre_i = 1'b1;
        data_i = 8'h11;
        tick();
        valid_pre_i = 1'b0;
        #1;
        total_cnt++; if (valid_post_o !== 1'b0) $display("FAIL lat_t1_valid got=%b exp=0", valid_post_o); else pass_cnt++;
        total_cnt++; if (occupancy_o !== 2'd1) $display("FAIL lat_t1_occ got=%0d exp=1", occupancy_o); else pass_cnt++;
        tick();
        total_cnt++; if (valid_post_o !== 1'b1) $display("FAIL lat_t2_valid got=%b exp=1", valid_post_o); else pass_cnt++;
        total_cnt++; if (data_o !== 8'h11) $display("FAIL lat_t2_data got=%h exp=11", data_o); else pass_cnt++;
        tick();
        total_cnt++; if (occupancy_o !== 2'd0) $display("FAIL lat_drain_occ got=%0d exp=0", occupancy_o); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        ready_post_i = 1'b1;
        for (int i = 0; i < 18; i++) begin
            valid_pre_i = (i < 16);
            data_i = 8'(i + 1);
            #1;
            total_cnt++; if (ready_pre_o !== 1'b1) $display("FAIL stream_ready i=%0d got=%b exp=1", i, ready_pre_o); else pass_cnt++;
            tick();
            if (i >= 1) begin
                total_cnt++; if (valid_post_o !== (i <= 16)) $display("FAIL stream_valid i=%0d got=%b exp=%b", i, valid_post_o, (i <= 16)); else pass_cnt++;
                if (i <= 16) begin
                    total_cnt++; if (data_o !== 8'(i)) $display("FAIL stream_data i=%0d got=%h exp=%h", i, data_o, 8'(i)); else pass_cnt++;
                end
            end
        end
        valid_pre_i = 1'b0;
    endtask

    task automatic test_backpressure();
        ready_post_i = 1'b0;
        valid_pre_i = 1'b1;
        data_i = 8'hA0;
        #1;
        total_cnt++; if (ready_pre_o !== 1'b1) $display("FAIL bp_a0_ready got=%b exp=1", ready_pre_o); else pass_cnt++;
        tick();
        data_i = 8'hA1;
        #1;
        total_cnt++; if (ready_pre_o !== 1'b1) $display("FAIL bp_a1_ready got=%b exp=1", ready_pre_o); else pass_cnt++;
        tick();
        data_i = 8'hA2;
        #1;
        total_cnt++; if (ready_pre_o !== 1'b0) $display("FAIL bp_a2_ready got=%b exp=0", ready_pre_o); else pass_cnt++;
        total_cnt++; if (occupancy_o !== 2'd2) $display("FAIL bp_full_occ got=%0d exp=2", occupancy_o); else pass_cnt++;
        total_cnt++; if (data_o !== 8'hA0) $display("FAIL bp_head_data got=%h exp=a0", data_o); else pass_cnt++;
        repeat (2) begin
            tick();
            total_cnt++; if (valid_post_o !== 1'b1 || data_o !== 8'hA0) $display("FAIL bp_stable got=%b/%h exp=1/a0", valid_post_o, data_o); else pass_cnt++;
            total_cnt++; if (ready_pre_o !== 1'b0) $display("FAIL bp_hold_ready got=%b exp=0", ready_pre_o); else pass_cnt++;
        end
        ready_post_i = 1'b1;
        #1;
        total_cnt++; if (ready_pre_o !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", ready_pre_o); else pass_cnt++;
        tick();
        valid_pre_i = 1'b0;
        total_cnt++; if (data_o !== 8'hA1) $display("FAIL bp_drain1 got=%h exp=a1", data_o); else pass_cnt++;
        tick();
        total_cnt++; if (data_o !== 8'hA2 || occupancy_o !== 2'd1) $display("FAIL bp_drain2 got=%h/%0d exp=a2/1", data_o, occupancy_o); else pass_cnt++;
        tick();
        total_cnt++; if (valid_post_o !== 1'b0 || occupancy_o !== 2'd0) $display("FAIL bp_empty got=%b/%0d exp=0/0", valid_post_o, occupancy_o); else pass_cnt++;
    endtask

    task automatic test_full_accept_emit();
        ready_post_i = 1'b0;
        valid_pre_i = 1'b1;
        data_i = 8'hB0;
        tick();
        data_i = 8'hB1;
        tick();
        data_i = 8'hB2;
        ready_post_i = 1'b1;
        #1;
        total_cnt++; if (ready_pre_o !== 1'b1) $display("FAIL full_both_ready got=%b exp=1", ready_pre_o); else pass_cnt++;
        tick();
        total_cnt++; if (occupancy_o !== 2'd2 || data_o !== 8'hB1) $display("FAIL full_shift1 got=%0d/%h exp=2/b1", occupancy_o, data_o); else pass_cnt++;
        data_i = 8'hB3;
        #1;
        total_cnt++; if (ready_pre_o !== 1'b1) $display("FAIL full_shift_ready got=%b exp=1", ready_pre_o); else pass_cnt++;
        tick();
        valid_pre_i = 1'b0;
        total_cnt++; if (occupancy_o !== 2'd2 || data_o !== 8'hB2) $display("FAIL full_shift2 got=%0d/%h exp=2/b2", occupancy_o, data_o); else pass_cnt++;
        tick();
        total_cnt++; if (occupancy_o !== 2'd1 || data_o !== 8'hB3) $display("FAIL full_drain got=%0d/%h exp=1/b3", occupancy_o, data_o); else pass_cnt++;
        tick();
        total_cnt++; if (occupancy_o !== 2'd0) $display("FAIL full_empty got=%0d exp=0", occupancy_o); else pass_cnt++;
    endtask

    task automatic test_flush();
        ready_post_i = 1'b0;
        valid_pre_i = 1'b1;
        data_i = 8'hC0;
        tick();
        data_i = 8'hC1;
        tick();
        ready_post_i = 1'b1;
        flush_i = 1'b1;
        data_i = 8'hC2;
        #1;
        total_cnt++; if (ready_pre_o !== 1'b0) $display("FAIL flush_ready got=%b exp=0", ready_pre_o); else pass_cnt++;
        tick();
        flush_i = 1'b0;
        valid_pre_i = 1'b0;
        #1;
        total_cnt++; if (occupancy_o !== 2'd0 || valid_post_o !== 1'b0) $display("FAIL flush_clear got=%0d/%b exp=0/0", occupancy_o, valid_post_o); else pass_cnt++;
        total_cnt++; if (data_o !== 8'hC0) $display("FAIL flush_data_hold got=%h exp=c0", data_o); else pass_cnt++;
        tick();
    endtask

    task automatic test_async_reset();
        ready_post_i = 1'b0;
        valid_pre_i = 1'b1;
        data_i = 8'hD0;
        tick();
        data_i = 8'hD1;
        tick();
        valid_pre_i = 1'b0;
        #1;
        total_cnt++; if (valid_post_o !== 1'b1 || data_o !== 8'hD0) $display("FAIL arst_pre got=%b/%h exp=1/d0", valid_post_o, data_o); else pass_cnt++;
        reset_n = 1'b0;
        #1;
        total_cnt++; if (valid_post_o !== 1'b0) $display("FAIL arst_valid got=%b exp=0", valid_post_o); else pass_cnt++;
        total_cnt++; if (data_o !== 8'h00) $display("FAIL arst_data got=%h exp=00", data_o); else pass_cnt++;
        total_cnt++; if (occupancy_o !== 2'd0) $display("FAIL arst_occ got=%0d exp=0", occupancy_o); else pass_cnt++;
        total_cnt++; if (ready_pre_o !== 1'b1) $display("FAIL arst_ready got=%b exp=1", ready_pre_o); else pass_cnt++;
        #2;
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_full_accept_emit();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
